// File: rtl/me_pkg.sv
// Shared motion-estimation types and constants for the SAD engine and the
// motion-vector decision stage.
package me_pkg;

  localparam int SAD_W    = 14;
  localparam int SEARCH_R = 8;
  localparam int MV_W     = $clog2(SEARCH_R) + 1;

  typedef logic [SAD_W-1:0]        sad_t;
  typedef logic signed [MV_W-1:0]  mv_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } mvsel_state_t;

  localparam sad_t SAD_MAX  = '1;
  localparam mv_t  MV_FIRST = mv_t'(-SEARCH_R);
  localparam mv_t  MV_LAST  = mv_t'(SEARCH_R - 1);

  // Strict compare so that ties keep the earlier raster position.
  function automatic logic sad_better(input sad_t cand, input sad_t best);
    return cand < best;
  endfunction

endpackage

// File: rtl/mv_pos_counter.sv
// Raster-order candidate position counter over the full-search window:
// cx runs fastest, cy steps when cx wraps.
module mv_pos_counter
  import me_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic adv,
  output mv_t  cx,
  output mv_t  cy,
  output logic last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx <= MV_FIRST;
      cy <= MV_FIRST;
    end else if (clr) begin
      cx <= MV_FIRST;
      cy <= MV_FIRST;
    end else if (adv) begin
      if (cx == MV_LAST) begin
        cx <= MV_FIRST;
        cy <= cy + mv_t'(1);
      end else begin
        cx <= cx + mv_t'(1);
      end
    end
  end

  assign last = (cx == MV_LAST) && (cy == MV_LAST);

endmodule

// File: rtl/mv_select.sv
// Motion-vector decision stage: tracks the running minimum SAD over one
// search window and presents the winning MV on a valid/ready handshake.
module mv_select
  import me_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic sad_valid,
  input  sad_t sad_data,
  input  logic mv_ready,
  output logic mv_valid,
  output mv_t  mv_x,
  output mv_t  mv_y,
  output sad_t min_sad,
  output logic busy,
  output logic sad_drop
);

  mvsel_state_t state, state_nxt;
  logic clr, take, drop, last, better;
  mv_t  cx, cy, best_x, best_y;
  sad_t best_sad;

  mv_pos_counter u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .adv   (take),
    .cx    (cx),
    .cy    (cy),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: begin
        if (start)                  state_nxt = SCAN;
        else if (sad_valid && last) state_nxt = DONE;
      end
      DONE: if (mv_ready) state_nxt = start ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A start in SCAN takes priority over a coincident SAD, which is dropped.
  always_comb begin
    clr  = 1'b0;
    take = 1'b0;
    unique case (state)
      IDLE:    clr = start;
      SCAN: begin
        clr  = start;
        take = sad_valid && !start;
      end
      DONE:    clr = start && mv_ready;
      default: ;
    endcase
    drop = sad_valid && !take;
  end

  assign better = sad_better(sad_data, best_sad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_valid <= 1'b0;
      busy     <= 1'b0;
      sad_drop <= 1'b0;
      mv_x     <= '0;
      mv_y     <= '0;
      min_sad  <= '0;
      best_sad <= SAD_MAX;
      best_x   <= MV_FIRST;
      best_y   <= MV_FIRST;
    end else begin
      mv_valid <= (state_nxt == DONE);
      busy     <= (state_nxt != IDLE);
      sad_drop <= drop;
      if (clr) begin
        best_sad <= SAD_MAX;
        best_x   <= MV_FIRST;
        best_y   <= MV_FIRST;
      end else if (take) begin
        if (better) begin
          best_sad <= sad_data;
          best_x   <= cx;
          best_y   <= cy;
        end
        // The final candidate still takes part in the compare.
        if (last) begin
          min_sad <= better ? sad_data : best_sad;
          mv_x    <= better ? cx : best_x;
          mv_y    <= better ? cy : best_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_mv_select.sv
// Directed self-checking bench for mv_select.
module tb_mv_select;
  import me_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sad_valid = 1'b0;
  sad_t sad_data = '0;
  logic mv_ready = 1'b0;
  logic mv_valid, busy, sad_drop;
  mv_t  mv_x, mv_y;
  sad_t min_sad;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mv_select dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sad_valid (sad_valid),
    .sad_data  (sad_data),
    .mv_ready  (mv_ready),
    .mv_valid  (mv_valid),
    .mv_x      (mv_x),
    .mv_y      (mv_y),
    .min_sad   (min_sad),
    .busy      (busy),
    .sad_drop  (sad_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int sad_val(input int pat, input int k);
    case (pat)
      0:       return 500;
      1:       return (k == 137) ? 3 : 1000 - k;
      2:       return (k == 255) ? 0 : 16320;
      3:       return (k == 50) ? 5 : 1000;
      default: return 900;
    endcase
  endfunction

  task automatic pulse_start(output int t0);
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int pat, input int first, input int count, input bit gaps);
    for (int k = first; k < first + count; k++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      sad_valid = 1'b1;
      sad_data  = sad_t'(sad_val(pat, k));
      tick();
      sad_valid = 1'b0;
    end
  endtask

  task automatic check_result(input string tag, input int x, input int y, input int s);
    chk({tag, "_valid"}, mv_valid, 1);
    chk({tag, "_x"}, mv_x, x);
    chk({tag, "_y"}, mv_y, y);
    chk({tag, "_sad"}, min_sad, s);
  endtask

  task automatic accept(input string tag);
    mv_ready = 1'b1;
    tick();
    mv_ready = 1'b0;
    chk({tag, "_acc_valid"}, mv_valid, 0);
    chk({tag, "_acc_busy"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1;
    bit stable;

    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", mv_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", sad_drop, 0);
    chk("rst_x", mv_x, 0);
    chk("rst_y", mv_y, 0);
    chk("rst_sad", min_sad, 0);
    rst_n = 1'b1;
    tick();

    // Flat window: first position wins all ties; exact latency.
    pulse_start(t0);
    chk("busy_rise", busy, 1);
    feed(0, 0, 255, 1'b0);
    chk("valid_early", mv_valid, 0);
    feed(0, 255, 1, 1'b0);
    chk("latency", cyc - t0, 257);
    check_result("flat", -8, -8, 500);
    accept("flat");

    pulse_start(t0);
    feed(1, 0, 256, 1'b0);
    check_result("ramp", 1, 0, 3);
    accept("ramp");

    pulse_start(t0);
    feed(2, 0, 256, 1'b0);
    check_result("last", 7, 7, 0);
    accept("last");

    pulse_start(t0);
    feed(2, 0, 256, 1'b1);
    check_result("gaps", 7, 7, 0);

    // Hold in DONE with mv_ready low.
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (mv_valid !== 1'b1 || mv_x !== mv_t'(7) || mv_y !== mv_t'(7) || min_sad !== '0)
        stable = 1'b0;
    end
    chk("hold_stable", stable, 1);

    // sad_valid and start without mv_ready in DONE are both ignored.
    sad_valid = 1'b1;
    sad_data  = sad_t'(1);
    start     = 1'b1;
    tick();
    sad_valid = 1'b0;
    start     = 1'b0;
    chk("drop_done", sad_drop, 1);
    tick();
    chk("drop_end", sad_drop, 0);
    check_result("done_kept", 7, 7, 0);

    // start together with mv_ready: straight into a new scan.
    start    = 1'b1;
    mv_ready = 1'b1;
    tick();
    start    = 1'b0;
    mv_ready = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_valid", mv_valid, 0);

    // Abort after 100 candidates; the aborting cycle also carries a SAD.
    feed(3, 0, 100, 1'b0);
    chk("partial_valid", mv_valid, 0);
    start     = 1'b1;
    sad_valid = 1'b1;
    sad_data  = sad_t'(1);
    tick();
    start     = 1'b0;
    sad_valid = 1'b0;
    chk("abort_drop", sad_drop, 1);
    feed(4, 0, 256, 1'b0);
    check_result("abort", -8, -8, 900);
    accept("abort");

    // Reset mid-scan after 200 candidates.
    pulse_start(t0);
    feed(1, 0, 200, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", mv_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_x", mv_x, 0);
    chk("mrst_y", mv_y, 0);
    chk("mrst_sad", min_sad, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mrst_idle", busy, 0);
    pulse_start(t0);
    feed(1, 0, 256, 1'b0);
    check_result("after_rst", 1, 0, 3);
    accept("after_rst");

    // Back-to-back windows with mv_ready tied high.
    mv_ready = 1'b1;
    pulse_start(t0);
    feed(0, 0, 256, 1'b0);
    check_result("b2b_a", -8, -8, 500);
    start = 1'b1;
    t1 = cyc;
    tick();
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    feed(4, 0, 256, 1'b0);
    chk("b2b_period", cyc - t1, 257);
    check_result("b2b_b", -8, -8, 900);
    tick();
    mv_ready = 1'b0;
    chk("b2b_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mv_select.md
# mv_select

Motion-vector decision stage directly downstream of the SAD engine. Consumes one 14-bit block SAD per candidate position, streamed in raster order over a full-search window, and tracks the running minimum. At the end of the window it presents the winning motion vector and its SAD on a valid/ready output handshake for the MV writeback stage.

## Interface
- `SAD_W`, 14: SAD width; 8x8 block of 8-bit pixels, max 16320.
- `SEARCH_R`, 8: search range; candidates dx, dy in [-SEARCH_R, SEARCH_R-1]; N = (2·SEARCH_R)² = 256.
- `MV_W`, 4: signed MV component width, $clog2(SEARCH_R)+1.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse; begin a new search window for the next block.
- `sad_valid` in 1: `sad_data` is a candidate result this cycle.
- `sad_data` in SAD_W: SAD of current candidate.
- `mv_ready` in 1: downstream accepts the result.
- `mv_valid` out 1: result valid; held until accepted.
- `mv_x` out MV_W: signed best dx.
- `mv_y` out MV_W: signed best dy.
- `min_sad` out SAD_W: SAD at best position.
- `busy` out 1: high in SCAN and DONE.
- `sad_drop` out 1: one-cycle pulse when a `sad_valid` is ignored.

## Operation
- FSM states IDLE, SCAN, DONE. Reset state IDLE.
- IDLE: on `start`, go to SCAN; clear candidate index (cx = cy = -SEARCH_R), set best SAD to all-ones, best MV to (-SEARCH_R, -SEARCH_R).
- SCAN: each `sad_valid` consumes one candidate at the current (cx, cy).
  - Update best when `sad_data` < best (strict). Ties keep the earlier raster position.
  - Advance cx; at cx = SEARCH_R-1, wrap to -SEARCH_R and increment cy.
  - On the N-th candidate (cx = cy = SEARCH_R-1), go to DONE. The compare includes this last value.
  - `sad_valid` low: hold; gaps of any length are legal.
- DONE: `mv_valid`=1; `mv_x`, `mv_y`, `min_sad` stable until `mv_ready`.
  - `mv_valid && mv_ready`: go to IDLE.
  - If `start` is also high in that cycle, go directly to SCAN with state cleared.
- `start` in SCAN: abort the current window and restart from the clear state. Partial result is discarded.
- `start` in DONE without `mv_ready`: ignored.
- `sad_valid` in IDLE or DONE: ignored; `sad_drop` pulses the next cycle.
- `start` in SCAN with `sad_valid` high: restart wins. The SAD is dropped and `sad_drop` pulses.
- Compare is unsigned at SAD_W bits; no saturation is needed.

## Timing
- Reset values: `mv_valid`=0, `mv_x`=0, `mv_y`=0, `min_sad`=0, `busy`=0, `sad_drop`=0.
- All outputs are registered.
- `mv_valid` rises the cycle after the last `sad_valid`.
- `busy` rises the cycle after `start`.
- Minimum window latency from `start` to `mv_valid`: N+1 cycles.
- Back-to-back operation: one window per N+1 cycles when `mv_ready` is tied high and `start` is pulsed in the accept cycle.
- `rst_n` low mid-scan: immediate return to IDLE and all outputs to reset values. No result is emitted.

## Structure
- Shared package `me_pkg`:
  - `SAD_W`, `SEARCH_R`, `MV_W`.
  - Typedefs `sad_t` and `mv_t` (signed MV_W).
  - FSM state enum `mvsel_state_t`.
  - Constant `SAD_MAX` = all-ones.
- One sub-module, `mv_pos_counter`: raster cx/cy counter with clear, advance and last-candidate flag.

## Test plan
- All 256 SADs = 500 -> `mv_valid` with (-8,-8), `min_sad`=500, exactly N+1 cycles after `start`.
- Ramp SAD = 1000-k, except k=137 -> 3 -> (1,0), `min_sad`=3.
- Minimum only at the last candidate (value 0, others 16320) -> (7,7), `min_sad`=0. Random `sad_valid` gaps give an identical result.
- `mv_ready` held low 20 cycles -> outputs stable. `sad_valid` during DONE -> `sad_drop` pulses, result unchanged. `start` with `mv_ready` -> new scan with no idle cycle.
- `start` after 100 candidates (minimum 5 at k=50), then new window with all 900 -> (-8,-8), `min_sad`=900.
- `rst_n` low at candidate 200 -> all outputs 0, IDLE. Next full window -> correct result.
